spi_master_tx: RTL and testbench

SPI master (mode 0: CPOL=0, CPHA=0, MSB first) that serialises one parallel word per transfer onto `mosi`, generating `sclk` and `cs_n`, and captures the word returned on `miso`. It is the outbound counterpart to the input synchronising/debouncing stage: that stage conditions signals entering the FPGA, while this block drives the SPI bus leaving the Cyclone 10 LP. It also synchronises its single external input, `miso`, internally. The upstream logic hands it words through a valid/ready handshake.

---
 rtl/spi_master_tx.sv | 122 ++++++++++++
 tb/tb_spi_master_tx.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/spi_master_tx.sv
// SPI mode-0 master: serialises one DATA_W word per valid/ready handshake, MSB first,
// and captures the word returned on miso through a 2-flop synchroniser.
module spi_master_tx #(
  parameter int CLK_DIV = 4,
  parameter int DATA_W  = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] tx_data,
  input  logic              tx_valid,
  output logic              tx_ready,
  output logic [DATA_W-1:0] rx_data,
  output logic              rx_valid,
  output logic              sclk,
  output logic              mosi,
  output logic              cs_n,
  input  logic              miso
);

  localparam int PH_W  = $clog2(CLK_DIV);
  localparam int BIT_W = $clog2(DATA_W);

  typedef enum logic [2:0] {IDLE, SETUP, HIGH, LOW, HOLD, GAP} state_t;

  state_t            state, next_state;
  logic [PH_W-1:0]   phase;
  logic [BIT_W-1:0]  bit_cnt;
  logic [DATA_W-2:0] tx_shift;     // bits still to be sent after the one on mosi
  logic [DATA_W-1:0] rx_shift;
  logic              miso_meta, miso_sync;
  logic              phase_done, last_bit, handshake, enter_gap;

  assign phase_done = (phase == PH_W'(CLK_DIV - 1));
  assign last_bit   = (bit_cnt == BIT_W'(DATA_W - 1));
  assign handshake  = (state == IDLE) && tx_valid;
  assign enter_gap  = (state == HOLD) && (next_state == GAP);

  // NOTE: every output of always_comb gets a default first, so no path can infer a latch.
  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (tx_valid)   next_state = SETUP;
      SETUP:   if (phase_done) next_state = HIGH;
      HIGH:    if (phase_done) next_state = last_bit ? HOLD : LOW;
      LOW:     if (phase_done) next_state = HIGH;
      HOLD:    if (phase_done) next_state = GAP;
      GAP:     if (phase_done) next_state = IDLE;
      default:                 next_state = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= next_state;
  end

  // Pins are registered from next_state so they line up exactly with the state they describe.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tx_ready <= 1'b1;
      cs_n     <= 1'b1;
      sclk     <= 1'b0;
    end else begin
      tx_ready <= (next_state == IDLE);
      cs_n     <= (next_state == IDLE) || (next_state == GAP);
      sclk     <= (next_state == HIGH);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      phase   <= '0;
      bit_cnt <= '0;
    end else begin
      if (state == IDLE || next_state != state) phase <= '0;
      else                                      phase <= phase + PH_W'(1);

      if (state == IDLE)                  bit_cnt <= '0;
      else if (state == HIGH && phase_done) bit_cnt <= bit_cnt + BIT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      miso_meta <= 1'b0;
      miso_sync <= 1'b0;
    end else begin
      miso_meta <= miso;
      miso_sync <= miso_meta;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tx_shift <= '0;
      mosi     <= 1'b0;
    end else if (handshake) begin
      tx_shift <= tx_data[DATA_W-2:0];
      mosi     <= tx_data[DATA_W-1];
    end else if (state == HIGH && next_state == LOW) begin
      mosi     <= tx_shift[DATA_W-2];
      tx_shift <= tx_shift << 1;
    end else if (enter_gap) begin
      mosi     <= 1'b0;
    end
  end

  // The sample is taken in the last cycle of HIGH, well after the slave's falling-edge update.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_shift <= '0;
      rx_data  <= '0;
      rx_valid <= 1'b0;
    end else begin
      if (state == HIGH && phase_done) rx_shift <= {rx_shift[DATA_W-2:0], miso_sync};
      if (enter_gap) rx_data <= rx_shift;
      rx_valid <= enter_gap;
    end
  end

endmodule

// File: tb/tb_spi_master_tx.sv
// Directed bench for spi_master_tx: one instance at CLK_DIV=4 and one at CLK_DIV=3,
// each with a behavioural mode-0 slave; timing is measured relative to the handshake edge.
module tb_spi_master_tx;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] tx_data;
  logic       tx_valid;

  logic       tx_ready4, rx_valid4, sclk4, mosi4, cs_n4, miso4;
  logic [7:0] rx_data4;
  logic       tx_ready3, rx_valid3, sclk3, mosi3, cs_n3, miso3;
  logic [7:0] rx_data3;

  spi_master_tx #(.CLK_DIV(4), .DATA_W(8)) dut (
    .clk(clk), .rst(rst), .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready4),
    .rx_data(rx_data4), .rx_valid(rx_valid4), .sclk(sclk4), .mosi(mosi4), .cs_n(cs_n4),
    .miso(miso4)
  );

  spi_master_tx #(.CLK_DIV(3), .DATA_W(8)) dut3 (
    .clk(clk), .rst(rst), .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready3),
    .rx_data(rx_data3), .rx_valid(rx_valid3), .sclk(sclk3), .mosi(mosi3), .cs_n(cs_n3),
    .miso(miso3)
  );

  always #5 clk = ~clk;

  // Mode-0 slave: first bit valid when cs_n falls, next bit after each falling sclk.
  logic [7:0] slave_word = 8'h00;
  int idx4 = 0, idx3 = 0;
  initial begin miso4 = 1'b0; miso3 = 1'b0; end
  always @(negedge cs_n4) begin miso4 = slave_word[7]; idx4 = 6; end
  always @(negedge sclk4) if (cs_n4 === 1'b0 && idx4 >= 0) begin miso4 = slave_word[idx4]; idx4--; end
  always @(negedge cs_n3) begin miso3 = slave_word[7]; idx3 = 6; end
  always @(negedge sclk3) if (cs_n3 === 1'b0 && idx3 >= 0) begin miso3 = slave_word[idx3]; idx3--; end

  bit use3 = 1'b0;
  wire       m_tx_ready = use3 ? tx_ready3 : tx_ready4;
  wire       m_rx_valid = use3 ? rx_valid3 : rx_valid4;
  wire       m_sclk     = use3 ? sclk3     : sclk4;
  wire       m_mosi     = use3 ? mosi3     : mosi4;
  wire       m_cs_n     = use3 ? cs_n3     : cs_n4;
  wire [7:0] m_rx_data  = use3 ? rx_data3  : rx_data4;

  int checks = 0;
  int errors = 0;

  int         obs_edges, obs_first_edge, obs_last_edge, obs_rx_at, obs_rx_cnt;
  int         obs_ready_at, obs_cs_low, obs_cs_high_tail;
  logic [7:0] obs_mosi, obs_rx_data;

  task automatic start_xfer(input logic [7:0] data);
    @(negedge clk);
    tx_data  = data;
    tx_valid = 1'b1;
    @(posedge clk);
  endtask

  // Observation j is the cycle T+j after handshake edge T; stops when tx_ready returns.
  task automatic monitor_xfer(input bit hold, input bit churn);
    logic prev_sclk = 1'b0;
    bit   seen_low  = 1'b0;
    obs_edges = 0; obs_first_edge = -1; obs_last_edge = -1; obs_rx_at = -1; obs_rx_cnt = 0;
    obs_ready_at = -1; obs_cs_low = 0; obs_cs_high_tail = 0; obs_mosi = '0; obs_rx_data = '0;
    for (int j = 1; j <= 300; j++) begin
      @(negedge clk);
      if (m_sclk === 1'b1 && prev_sclk === 1'b0) begin
        obs_edges++;
        obs_mosi = {obs_mosi[6:0], m_mosi};
        if (obs_first_edge < 0) obs_first_edge = j;
        obs_last_edge = j;
      end
      prev_sclk = m_sclk;
      if (m_cs_n === 1'b0) begin obs_cs_low++; seen_low = 1'b1; end
      else if (seen_low) obs_cs_high_tail++;
      if (m_rx_valid === 1'b1) begin obs_rx_cnt++; obs_rx_at = j; obs_rx_data = m_rx_data; end
      if (m_tx_ready === 1'b1) begin
        obs_ready_at = j;
        if (!hold) tx_valid = 1'b0;
        break;
      end
      if (j == 1 && !hold) tx_valid = 1'b0;
      if (churn) begin tx_data = 8'($urandom); tx_valid = ~tx_valid; end
    end
  endtask

  task automatic test_reset;
    rst = 1'b1; tx_valid = 1'b1; tx_data = 8'hA5;
    #12;
    checks++; if (cs_n4 !== 1'b1)      begin errors++; $display("FAIL reset_cs_n: got %b expected 1", cs_n4); end
    checks++; if (sclk4 !== 1'b0)      begin errors++; $display("FAIL reset_sclk: got %b expected 0", sclk4); end
    checks++; if (mosi4 !== 1'b0)      begin errors++; $display("FAIL reset_mosi: got %b expected 0", mosi4); end
    checks++; if (tx_ready4 !== 1'b1)  begin errors++; $display("FAIL reset_tx_ready: got %b expected 1", tx_ready4); end
    checks++; if (rx_valid4 !== 1'b0)  begin errors++; $display("FAIL reset_rx_valid: got %b expected 0", rx_valid4); end
    checks++; if (rx_data4 !== 8'h00)  begin errors++; $display("FAIL reset_rx_data: got %h expected 00", rx_data4); end
    @(negedge clk);
    tx_valid = 1'b0; rst = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (cs_n4 !== 1'b1)      begin errors++; $display("FAIL idle_after_reset_cs_n: got %b expected 1", cs_n4); end
  endtask

  task automatic test_single;
    use3 = 1'b0; slave_word = 8'h3C;
    start_xfer(8'hA5);
    monitor_xfer(1'b0, 1'b0);
    checks++; if (obs_edges !== 8)          begin errors++; $display("FAIL single_edges: got %0d expected 8", obs_edges); end
    checks++; if (obs_mosi !== 8'hA5)       begin errors++; $display("FAIL single_mosi: got %h expected a5", obs_mosi); end
    checks++; if (obs_first_edge !== 5)     begin errors++; $display("FAIL single_first_edge: got T+%0d expected T+5", obs_first_edge); end
    checks++; if (obs_last_edge !== 61)     begin errors++; $display("FAIL single_last_edge: got T+%0d expected T+61", obs_last_edge); end
    checks++; if (obs_cs_low !== 68)        begin errors++; $display("FAIL single_cs_low: got %0d expected 68", obs_cs_low); end
    checks++; if (obs_rx_at !== 69)         begin errors++; $display("FAIL single_rx_at: got T+%0d expected T+69", obs_rx_at); end
    checks++; if (obs_rx_cnt !== 1)         begin errors++; $display("FAIL single_rx_pulses: got %0d expected 1", obs_rx_cnt); end
    checks++; if (obs_rx_data !== 8'h3C)    begin errors++; $display("FAIL single_rx_data: got %h expected 3c", obs_rx_data); end
    checks++; if (obs_ready_at !== 73)      begin errors++; $display("FAIL single_ready_at: got T+%0d expected T+73", obs_ready_at); end
    checks++; if (m_rx_data !== 8'h3C)      begin errors++; $display("FAIL single_rx_hold: got %h expected 3c", m_rx_data); end
  endtask

  task automatic test_back_to_back;
    use3 = 1'b0; slave_word = 8'h81;
    start_xfer(8'hFF);
    monitor_xfer(1'b1, 1'b0);
    checks++; if (obs_mosi !== 8'hFF)       begin errors++; $display("FAIL b2b_first_mosi: got %h expected ff", obs_mosi); end
    checks++; if (obs_ready_at !== 73)      begin errors++; $display("FAIL b2b_first_ready: got T+%0d expected T+73", obs_ready_at); end
    checks++; if (obs_cs_high_tail !== 5)   begin errors++; $display("FAIL b2b_cs_high_gap: got %0d expected 5", obs_cs_high_tail); end
    checks++; if (obs_rx_data !== 8'h81)    begin errors++; $display("FAIL b2b_first_rx: got %h expected 81", obs_rx_data); end
    tx_data = 8'h00;
    @(posedge clk);
    monitor_xfer(1'b0, 1'b0);
    checks++; if (obs_cs_low !== 68)        begin errors++; $display("FAIL b2b_second_start: cs_n low %0d cycles expected 68", obs_cs_low); end
    checks++; if (obs_edges !== 8)          begin errors++; $display("FAIL b2b_second_edges: got %0d expected 8", obs_edges); end
    checks++; if (obs_mosi !== 8'h00)       begin errors++; $display("FAIL b2b_second_mosi: got %h expected 00", obs_mosi); end
    checks++; if (obs_rx_data !== 8'h81)    begin errors++; $display("FAIL b2b_second_rx: got %h expected 81", obs_rx_data); end
  endtask

  task automatic test_busy;
    int bad = 0;
    use3 = 1'b0; slave_word = 8'h24;
    start_xfer(8'h5A);
    monitor_xfer(1'b0, 1'b1);
    checks++; if (obs_mosi !== 8'h5A)       begin errors++; $display("FAIL busy_mosi: got %h expected 5a", obs_mosi); end
    checks++; if (obs_edges !== 8)          begin errors++; $display("FAIL busy_edges: got %0d expected 8", obs_edges); end
    checks++; if (obs_ready_at !== 73)      begin errors++; $display("FAIL busy_ready_at: got T+%0d expected T+73", obs_ready_at); end
    checks++; if (obs_rx_data !== 8'h24)    begin errors++; $display("FAIL busy_rx: got %h expected 24", obs_rx_data); end
    for (int j = 0; j < 12; j++) begin
      @(negedge clk);
      if (m_cs_n !== 1'b1 || m_tx_ready !== 1'b1) bad++;
    end
    checks++; if (bad !== 0)                begin errors++; $display("FAIL busy_no_extra: %0d busy cycles expected 0", bad); end
  endtask

  task automatic test_reset_mid;
    int pulses = 0;
    int low_cycles = 0;
    use3 = 1'b0; slave_word = 8'h99;
    start_xfer(8'h96);
    for (int j = 1; j <= 31; j++) begin
      @(negedge clk);
      if (j == 1) tx_valid = 1'b0;
    end
    checks++; if (m_sclk !== 1'b1)          begin errors++; $display("FAIL mid_in_high: sclk %b expected 1", m_sclk); end
    #2 rst = 1'b1;
    #1;
    checks++; if (m_cs_n !== 1'b1)          begin errors++; $display("FAIL mid_cs_n: got %b expected 1", m_cs_n); end
    checks++; if (m_sclk !== 1'b0)          begin errors++; $display("FAIL mid_sclk: got %b expected 0", m_sclk); end
    checks++; if (m_mosi !== 1'b0)          begin errors++; $display("FAIL mid_mosi: got %b expected 0", m_mosi); end
    checks++; if (m_rx_data !== 8'h00)      begin errors++; $display("FAIL mid_rx_data: got %h expected 00", m_rx_data); end
    repeat (2) @(negedge clk);
    rst = 1'b0;
    for (int j = 0; j < 80; j++) begin
      @(negedge clk);
      if (m_rx_valid === 1'b1) pulses++;
      if (m_cs_n !== 1'b1) low_cycles++;
    end
    checks++; if (pulses !== 0)             begin errors++; $display("FAIL mid_no_rx_valid: got %0d pulses expected 0", pulses); end
    checks++; if (low_cycles !== 0)         begin errors++; $display("FAIL mid_abandoned: cs_n low %0d cycles expected 0", low_cycles); end
    slave_word = 8'h5B;
    start_xfer(8'hC3);
    monitor_xfer(1'b0, 1'b0);
    checks++; if (obs_mosi !== 8'hC3)       begin errors++; $display("FAIL mid_after_mosi: got %h expected c3", obs_mosi); end
    checks++; if (obs_rx_data !== 8'h5B)    begin errors++; $display("FAIL mid_after_rx: got %h expected 5b", obs_rx_data); end
    checks++; if (obs_rx_at !== 69)         begin errors++; $display("FAIL mid_after_rx_at: got T+%0d expected T+69", obs_rx_at); end
  endtask

  task automatic test_div3;
    @(negedge clk); rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    use3 = 1'b1; slave_word = 8'h7E;
    start_xfer(8'h81);
    monitor_xfer(1'b0, 1'b0);
    checks++; if (obs_mosi !== 8'h81)       begin errors++; $display("FAIL div3_mosi: got %h expected 81", obs_mosi); end
    checks++; if (obs_first_edge !== 4)     begin errors++; $display("FAIL div3_first_edge: got T+%0d expected T+4", obs_first_edge); end
    checks++; if (obs_cs_low !== 51)        begin errors++; $display("FAIL div3_cs_low: got %0d expected 51", obs_cs_low); end
    checks++; if (obs_rx_at !== 52)         begin errors++; $display("FAIL div3_rx_at: got T+%0d expected T+52", obs_rx_at); end
    checks++; if (obs_rx_data !== 8'h7E)    begin errors++; $display("FAIL div3_rx_data: got %h expected 7e", obs_rx_data); end
    checks++; if (obs_ready_at !== 55)      begin errors++; $display("FAIL div3_ready_at: got T+%0d expected T+55", obs_ready_at); end
    use3 = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_busy();
    test_reset_mid();
    test_div3();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
